multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised, multi-channel successor to the single fixed divider. It turns the 50 MHz board clock into CHANNELS independent slow strobes. Each channel has a runtime-loadable divisor, an enable, a one-cycle tick output and a near-50% duty square output. Divisor changes are glitch-free, and a global restart phase-aligns all channels. It sits between the board oscillator and the lab's slow-clocked logic: displays, debouncers and step clocks.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- WIDTH, 26: divisor and counter width in bits.
- DEFAULT_DIV, 50000000: reset divisor of every channel; must fit in WIDTH bits.
- clock50MHZ  input  1  sole clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  CHANNELS  per-channel run enable.
- restart  input  1  single-cycle pulse; phase-aligns all channels.
- load  input  1  single-cycle divisor write strobe.
- load_channel  input  $clog2(CHANNELS) (min 1)  target channel of a load.
- load_value  input  WIDTH  new divisor D.
- load_ack  output  1  pulses one cycle after a load accepted for a valid channel.
- load_err  output  1  pulses one cycle after a load with load_channel ≥ CHANNELS.
- tick  output  CHANNELS  one-cycle strobe per period.
- clock  output  CHANNELS  square output: high ceil(D/2) cycles, low floor(D/2) cycles.

## Operation
- Period is exactly D cycles. The earlier D+1 off-by-one is not reproduced.
- Per channel: active divisor `div`, shadow divisor `shadow`, pending flag `pend`, counter `c` (0..div−1).
- Reset values: `div` = `shadow` = DEFAULT_DIV, `pend` = 0, `c` = 0. All `tick`, `clock`, `load_ack` and `load_err` are 0.
- D = 0: channel is idle. `c` holds 0; `tick` and `clock` are 0 regardless of enable.
- D = 1, enabled: `tick` and `clock` are constantly 1.
- Enabled, div ≥ 1, per edge:
  - If `c` == div−1: `c` ← 0 and `tick` ← 1.
  - Otherwise: `c` ← `c`+1 and `tick` ← 0.
  - `clock` ← 1 when the next `c` < ceil(div/2), else 0. The rising edge of `clock` coincides with `tick`.
- Disabled: `c` ← 0, `tick` ← 0, `clock` ← 0 on the next edge.
- Re-enabling starts counting from 0.
- Load to a running channel:
  - `shadow` ← load_value and `pend` ← 1.
  - At the channel's next wrap (the edge with `c` == div−1), `div` ← `shadow` and `pend` ← 0.
  - The wrap period itself completes at the old divisor.
- Load to a disabled channel or one with div = 0: `div` ← load_value on the same edge, with no pending state.
- Back-to-back loads before a wrap: the last one wins.
- Invalid load_channel: no state change; `load_err` pulses.
- Restart, on the edge sampling it high, for every channel:
  - `c` ← 0, `tick` ← 0, `clock` ← 0.
  - Any pending shadow is applied immediately.
  - The enabled state is unchanged.
- Restart coinciding with a load: the load is written to `div` directly and acknowledged normally.
- Restart coinciding with a wrap: restart wins and no tick is produced.
- Enable falling while a load is pending: the shadow is applied on that edge.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Enable sampled high at edge k, channel starting from `c` = 0:
  - first `tick` asserts after edge k+D−1;
  - subsequent ticks every D edges;
  - each tick is high for exactly one cycle (D ≥ 2).
- `load_ack` / `load_err`: high for the one cycle after the edge that sampled `load`. Latency 1; there is no busy state, so a load is accepted every cycle.
- Divisor change latency: at most the remaining `c` cycles of the current period. The first full period at the new D starts immediately after the wrap edge.
- Restart at edge r: the first tick of a channel with divisor D follows edge r+D. All enabled channels with equal D tick on the same edge thereafter.
- Asynchronous reset assertion clears all state immediately. Deassertion is expected synchronised externally; the first counting edge is the first edge with reset_n high.

## Structure
- Package `clock_divider_pkg`:
  - `IDX_W(CHANNELS)` helper function;
  - `DEFAULT_DIV_50HZ` = 1000000 and `DEFAULT_DIV_1HZ` = 50000000 constants;
  - half-period helper `ceil_half(d)` = (d+1)>>1.
- Sub-module `divider_channel`: `div`, `shadow`, `pend`, counter, `tick` and `clock` for one channel. It is instantiated CHANNELS times through a generate loop.
- The top level decodes `load_channel`, drives `load_ack`/`load_err` and fans out `restart`.

## Test plan
- Reset, then enable ch0 with DEFAULT_DIV overridden to 4 → `tick[0]` after edges 3, 7, 11; `clock[0]` sequence 1,1,0,0 repeating.
- D = 5 on ch1 → `clock[1]` high 3 cycles and low 2 cycles, rising with `tick[1]`; D = 1 → `tick` and `clock` held at 1.
- Load 8 to running ch2 (D = 4) at `c` = 1 → `load_ack` next cycle; two more ticks spaced 4 apart, then spacing 8. A second load of 6 before the wrap → spacing 6 instead.
- Load with load_channel = CHANNELS → `load_err` = 1 for one cycle, `load_ack` = 0, all divisors unchanged.
- Channels with D = 3 and D = 6 at random phases, restart pulse at edge r → both `clock` outputs 0 at r; `tick` on edges r+3, r+6, r+9… for D = 3 and r+6, r+12… for D = 6, coinciding every 6.
- reset_n low mid-period with `clock` = 1 → all outputs 0 immediately without waiting for a clock edge; divisors back to DEFAULT_DIV after release.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   IDX_W(n)      : width of a channel index for n channels (at least 1 bit)
//   ceil_half(d)  : number of high cycles of a square output with period d
//   DEFAULT_DIV_* : common 50 MHz divisors (50 Hz and 1 Hz strobes)
package clock_divider_pkg;

  localparam int DEFAULT_DIV_50HZ = 1000000;
  localparam int DEFAULT_DIV_1HZ  = 50000000;

  function automatic int IDX_W(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic logic [63:0] ceil_half(input logic [63:0] d);
    return (d + 64'd1) >> 1;
  endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: active divisor, shadow divisor with pending flag,
// period counter and registered tick / square outputs.
//   clock50MHZ : clock
//   reset_n    : asynchronous active-low reset
//   enable     : run enable for this channel
//   restart    : phase-align pulse (counter to 0, pending divisor applied)
//   wr         : divisor write strobe addressed to this channel
//   wr_value   : divisor carried by the write
//   tick       : one-cycle strobe on the wrap edge
//   clock      : square output, high ceil(D/2) cycles, low floor(D/2)
module divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
  input  logic             clock50MHZ,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_value,
  output logic             tick,
  output logic             clock
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] div, shadow, c;
  logic             pend;

  logic [WIDTH-1:0] div_nx, shadow_nx, c_nx;
  logic             pend_nx, tick_nx, clock_nx;
  logic             running, wrap;

  always_comb begin
    div_nx    = div;
    shadow_nx = shadow;
    pend_nx   = pend;
    c_nx      = '0;
    tick_nx   = 1'b0;
    clock_nx  = 1'b0;
    running   = enable && (div != '0);
    wrap      = running && (c == div - ONE);

    if (restart || !running) begin
      // Parked or phase-aligning: counter held at 0 and any divisor change
      // takes effect at once, a fresh write overriding an older shadow.
      if (wr) begin
        div_nx    = wr_value;
        shadow_nx = wr_value;
        pend_nx   = 1'b0;
      end else if (pend) begin
        div_nx  = shadow;
        pend_nx = 1'b0;
      end
    end else begin
      if (wrap) begin
        c_nx    = '0;
        tick_nx = 1'b1;
        if (pend) div_nx = shadow;
        pend_nx = 1'b0;
      end else begin
        c_nx = c + ONE;
      end
      // A write seen on the wrap edge itself waits for the following wrap.
      if (wr) begin
        shadow_nx = wr_value;
        pend_nx   = 1'b1;
      end
      clock_nx = (div_nx != '0) && (64'(c_nx) < ceil_half(64'(div_nx)));
    end
  end

  always_ff @(posedge clock50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      div    <= DIV_RST;
      shadow <= DIV_RST;
      pend   <= 1'b0;
      c      <= '0;
      tick   <= 1'b0;
      clock  <= 1'b0;
    end else begin
      div    <= div_nx;
      shadow <= shadow_nx;
      pend   <= pend_nx;
      c      <= c_nx;
      tick   <= tick_nx;
      clock  <= clock_nx;
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// CHANNELS independent slow strobes derived from the 50 MHz board clock.
//   clock50MHZ   : sole clock
//   reset_n      : asynchronous active-low reset
//   enable       : per-channel run enable
//   restart      : one-cycle pulse, phase-aligns every channel
//   load         : one-cycle divisor write strobe
//   load_channel : target channel of the write
//   load_value   : new divisor
//   load_ack     : one-cycle pulse after a write to an existing channel
//   load_err     : one-cycle pulse after a write to a nonexistent channel
//   tick         : per-channel one-cycle strobe, once per period
//   clock        : per-channel near-50% square output
module multi_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
  input  logic                        clock50MHZ,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         enable,
  input  logic                        restart,
  input  logic                        load,
  input  logic [IDX_W(CHANNELS)-1:0]  load_channel,
  input  logic [WIDTH-1:0]            load_value,
  output logic                        load_ack,
  output logic                        load_err,
  output logic [CHANNELS-1:0]         tick,
  output logic [CHANNELS-1:0]         clock
);

  logic                chan_valid;
  logic [CHANNELS-1:0] wr;

  assign chan_valid = 32'(load_channel) < 32'(CHANNELS);

  always_ff @(posedge clock50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_ack <= load && chan_valid;
      load_err <= load && !chan_valid;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign wr[g] = load && (32'(load_channel) == 32'(g));

    divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clock50MHZ (clock50MHZ),
      .reset_n    (reset_n),
      .enable     (enable[g]),
      .restart    (restart),
      .wr         (wr[g]),
      .wr_value   (load_value),
      .tick       (tick[g]),
      .clock      (clock[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

  localparam int CH = 3;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] en;
  logic          rs;
  logic          ld;
  logic [1:0]    lch;
  logic [W-1:0]  lval;
  logic          ack, err;
  logic [CH-1:0] tick, clock;

  int checks = 0;
  int errors = 0;

  multi_clock_divider #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clock50MHZ   (clk),
    .reset_n      (reset_n),
    .enable       (en),
    .restart      (rs),
    .load         (ld),
    .load_channel (lch),
    .load_value   (lval),
    .load_ack     (ack),
    .load_err     (err),
    .tick         (tick),
    .clock        (clock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic       rs;
    logic       ld;
    logic [1:0] lch;
    logic [7:0] lval;
    logic [2:0] e_tick;
    logic [2:0] e_clock;
    logic       e_ack;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] e, input logic r, input logic l,
                     input logic [1:0] c, input logic [7:0] v,
                     input logic [2:0] t, input logic [2:0] k,
                     input logic a, input logic x);
    vec_t row;
    row.en = e; row.rs = r; row.ld = l; row.lch = c; row.lval = v;
    row.e_tick = t; row.e_clock = k; row.e_ack = a; row.e_err = x;
    tbl.push_back(row);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input bit second, input int x0, input int x1,
                          input int x2, input int x3, input string nm);
    int t[$];
    int xp[4];
    xp[0] = x0; xp[1] = x1; xp[2] = x2; xp[3] = x3;
    en = 3'b100; ld = 1'b0;
    cyc();
    for (int i = 0; i <= 24; i++) begin
      if (tick[2]) t.push_back(i);
      if (i == 5) chk({nm, "_ack1"}, 32'(ack), 32'd1);
      if (i == 6 && second) chk({nm, "_ack2"}, 32'(ack), 32'd1);
      ld = 1'b0;
      if (i == 4) begin ld = 1'b1; lch = 2'd2; lval = 8'd8; end
      if (i == 5 && second) begin ld = 1'b1; lch = 2'd2; lval = 8'd6; end
      cyc();
    end
    ld = 1'b0;
    chk({nm, "_nticks_ge4"}, 32'(t.size() >= 4), 32'd1);
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_tick%0d", nm, j), (j < t.size()) ? 32'(t[j]) : 32'hFFFF, 32'(xp[j]));
  endtask

  initial begin
    reset_n = 1'b0; en = '0; rs = 1'b0; ld = 1'b0; lch = '0; lval = '0;

    // ch0 at default D=4: ticks after edges 3,7,11; clock 1,1,0,0 from each tick
    add(3'b001,0,0,0,0, 3'b000,3'b001,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b001,0,0,0,0, 3'b001,3'b001,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b001,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b001,0,0,0,0, 3'b001,3'b001,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b001,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b001,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b001,0,0,0,0, 3'b001,3'b001,0,0);
    // disable, load 5 into idle ch1
    add(3'b000,0,1,1,5, 3'b000,3'b000,1,0);
    // ch1 D=5: clock high 3, low 2, rising with tick
    add(3'b010,0,0,0,0, 3'b000,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b010,0,0,0,0, 3'b010,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b010,0,0,0,0, 3'b000,3'b000,0,0);
    add(3'b010,0,0,0,0, 3'b010,3'b010,0,0);
    // D=1 on ch1: tick and clock held high
    add(3'b000,0,1,1,1, 3'b000,3'b000,1,0);
    add(3'b010,0,0,0,0, 3'b010,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b010,3'b010,0,0);
    add(3'b010,0,0,0,0, 3'b010,3'b010,0,0);
    // invalid channel 3: error, no ack
    add(3'b000,0,1,3,7, 3'b000,3'b000,0,1);
    add(3'b000,0,0,0,0, 3'b000,3'b000,0,0);
    // divisors unchanged: ch0=4, ch1=1, ch2=4
    add(3'b111,0,0,0,0, 3'b010,3'b111,0,0);
    add(3'b111,0,0,0,0, 3'b010,3'b010,0,0);
    add(3'b111,0,0,0,0, 3'b010,3'b010,0,0);
    add(3'b111,0,0,0,0, 3'b111,3'b111,0,0);
    add(3'b000,0,0,0,0, 3'b000,3'b000,0,0);

    cyc(); cyc();
    chk("rst_tick",  32'(tick),  32'd0);
    chk("rst_clock", 32'(clock), 32'd0);
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_err",   32'(err),   32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; rs = tbl[i].rs; ld = tbl[i].ld;
      lch = tbl[i].lch; lval = tbl[i].lval;
      cyc();
      chk($sformatf("v%0d_tick", i),  32'(tick),  32'(tbl[i].e_tick));
      chk($sformatf("v%0d_clock", i), 32'(clock), 32'(tbl[i].e_clock));
      chk($sformatf("v%0d_ack", i),   32'(ack),   32'(tbl[i].e_ack));
      chk($sformatf("v%0d_err", i),   32'(err),   32'(tbl[i].e_err));
    end
    en = '0; rs = 1'b0; ld = 1'b0;

    // load 8 to running ch2 at c=1: ticks 4 apart, then 8 apart
    load_seq(1'b0, 3, 7, 15, 23, "load8");
    en = '0; ld = 1'b1; lch = 2'd2; lval = 8'd4; cyc(); ld = 1'b0; cyc();
    // second load of 6 before the wrap wins
    load_seq(1'b1, 3, 7, 13, 19, "load6");
    en = '0; cyc();

    // restart aligns D=3 (ch0) and D=6 (ch1) started at different phases
    ld = 1'b1; lch = 2'd0; lval = 8'd3; cyc();
    lch = 2'd1; lval = 8'd6; cyc();
    ld = 1'b0;
    en = 3'b001; cyc(); cyc();
    en = 3'b011; cyc(); cyc(); cyc(); cyc();
    rs = 1'b1; cyc(); rs = 1'b0;
    chk("rs_clock", 32'(clock[1:0]), 32'd0);
    chk("rs_tick",  32'(tick[1:0]),  32'd0);
    for (int i = 1; i <= 18; i++) begin
      logic [1:0] et;
      cyc();
      et = {(i % 6 == 0) ? 1'b1 : 1'b0, (i % 3 == 0) ? 1'b1 : 1'b0};
      chk($sformatf("rs_tick_r+%0d", i), 32'(tick[1:0]), 32'(et));
    end

    // asynchronous reset while ch0 clock is high
    begin
      int n = 0;
      while (!clock[0] && n < 8) begin cyc(); n++; end
      chk("rst_wait_clock_high", 32'(clock[0]), 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tick",  32'(tick),  32'd0);
    chk("arst_clock", 32'(clock), 32'd0);
    chk("arst_ack",   32'(ack),   32'd0);
    chk("arst_err",   32'(err),   32'd0);
    en = '0;
    cyc(); cyc();
    reset_n = 1'b1;
    en = 3'b111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("post_rst_tick%0d", i), 32'(tick), (i == 3) ? 32'd7 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
